// File: rtl/ip_tx_resolver.sv
// ip_tx_resolver: resolves the next-hop Ethernet MAC for each outgoing IPv4
// datagram, then forwards or drops its payload.
//
// Resolution order: multicast mapping, limited/subnet broadcast, on-block
// fully-associative IP->MAC cache, then ARP request with timeout and retry.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_ip_hdr_*                 upstream header handshake + destination IP
//   s_ip_payload_axis_*        upstream payload flow control
//   m_ip_hdr_*, m_eth_dest_mac header and resolved MAC towards ip_eth_tx
//   m_ip_payload_axis_*        gated payload flow control towards ip_eth_tx
//   arp_request_*              ARP lookup request
//   arp_response_*             ARP lookup result
//   local_ip, subnet_mask      own address, used for subnet broadcast
//   cache_flush                invalidate every cache entry
//   tx_error_arp_failed        pulse when a packet is dropped
//   cache_hit                  pulse when the cache resolved a header
module ip_tx_resolver #(
    parameter int unsigned CACHE_ENTRIES = 4,
    parameter int unsigned ARP_TIMEOUT   = 1024,
    parameter int unsigned ARP_RETRIES   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_ip_hdr_valid,
    output logic        s_ip_hdr_ready,
    input  logic [31:0] s_ip_dest_ip,
    input  logic        s_ip_payload_axis_tvalid,
    output logic        s_ip_payload_axis_tready,
    input  logic        s_ip_payload_axis_tlast,
    output logic        m_ip_hdr_valid,
    input  logic        m_ip_hdr_ready,
    output logic [47:0] m_eth_dest_mac,
    output logic        m_ip_payload_axis_tvalid,
    input  logic        m_ip_payload_axis_tready,
    output logic        arp_request_valid,
    input  logic        arp_request_ready,
    output logic [31:0] arp_request_ip,
    input  logic        arp_response_valid,
    output logic        arp_response_ready,
    input  logic        arp_response_error,
    input  logic [47:0] arp_response_mac,
    input  logic [31:0] local_ip,
    input  logic [31:0] subnet_mask,
    input  logic        cache_flush,
    output logic        tx_error_arp_failed,
    output logic        cache_hit
);

    localparam int unsigned PTR_W = (CACHE_ENTRIES > 1) ? $clog2(CACHE_ENTRIES) : 1;
    localparam int unsigned TMR_W = $clog2(ARP_TIMEOUT) + 1;
    localparam int unsigned ATT_W = $clog2(ARP_RETRIES + 2);

    typedef enum logic [2:0] {StIdle, StArpReq, StArpWait, StSend, StDrop} state_e;

    state_e                   state_q, state_d;
    logic                     hdr_ready_q, hdr_ready_d;
    logic                     m_hdr_valid_q, m_hdr_valid_d;
    logic [47:0]              dest_mac_q, dest_mac_d;
    logic [31:0]              arp_ip_q, arp_ip_d;
    logic                     tx_err_q, tx_err_d;
    logic                     hit_q, hit_d;
    logic [TMR_W-1:0]         timer_q, timer_d;
    logic [ATT_W-1:0]         attempt_q, attempt_d;
    logic [PTR_W-1:0]         ptr_q, ptr_d;
    logic [CACHE_ENTRIES-1:0] valid_q, valid_d;
    logic [31:0]              cache_ip_q [CACHE_ENTRIES];
    logic [31:0]              cache_ip_d [CACHE_ENTRIES];
    logic [47:0]              cache_mac_q [CACHE_ENTRIES];
    logic [47:0]              cache_mac_d [CACHE_ENTRIES];

    logic        is_mcast, is_bcast, lookup_hit;
    logic [47:0] lookup_mac;

    // Classification of the offered destination.
    always_comb begin
        is_mcast = (s_ip_dest_ip[31:28] == 4'hE);
        is_bcast = (s_ip_dest_ip == 32'hFFFF_FFFF) ||
                   ((subnet_mask != 32'hFFFF_FFFF) &&
                    ((s_ip_dest_ip & ~subnet_mask) == ~subnet_mask) &&
                    ((s_ip_dest_ip & subnet_mask) == (local_ip & subnet_mask)));
        lookup_hit = 1'b0;
        lookup_mac = 48'h0;
        // Scan downward so the lowest matching index is the one kept.
        for (int i = CACHE_ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && (cache_ip_q[i] == s_ip_dest_ip)) begin
                lookup_hit = 1'b1;
                lookup_mac = cache_mac_q[i];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        hdr_ready_d   = 1'b0;
        m_hdr_valid_d = m_hdr_valid_q;
        dest_mac_d    = dest_mac_q;
        arp_ip_d      = arp_ip_q;
        tx_err_d      = 1'b0;
        hit_d         = 1'b0;
        timer_d       = timer_q;
        attempt_d     = attempt_q;
        ptr_d         = ptr_q;
        valid_d       = valid_q;
        cache_ip_d    = cache_ip_q;
        cache_mac_d   = cache_mac_q;

        unique case (state_q)
            StIdle: begin
                if (s_ip_hdr_valid) begin
                    if (is_mcast || is_bcast || lookup_hit) begin
                        state_d       = StSend;
                        hdr_ready_d   = 1'b1;
                        m_hdr_valid_d = 1'b1;
                        if (is_mcast) begin
                            dest_mac_d = {24'h01005E, 1'b0, s_ip_dest_ip[22:0]};
                        end else if (is_bcast) begin
                            dest_mac_d = 48'hFFFF_FFFF_FFFF;
                        end else begin
                            dest_mac_d = lookup_mac;
                            hit_d      = 1'b1;
                        end
                    end else begin
                        arp_ip_d  = s_ip_dest_ip;
                        attempt_d = '0;
                        state_d   = StArpReq;
                    end
                end
            end
            StArpReq: begin
                if (arp_request_ready) begin
                    timer_d = TMR_W'(ARP_TIMEOUT - 1);
                    state_d = StArpWait;
                end
            end
            StArpWait: begin
                if (arp_response_valid) begin
                    if (arp_response_error) begin
                        state_d     = StDrop;
                        hdr_ready_d = 1'b1;
                        tx_err_d    = 1'b1;
                    end else begin
                        valid_d[ptr_q]     = 1'b1;
                        cache_ip_d[ptr_q]  = arp_ip_q;
                        cache_mac_d[ptr_q] = arp_response_mac;
                        ptr_d = (ptr_q == PTR_W'(CACHE_ENTRIES - 1)) ? '0 : ptr_q + 1'b1;
                        dest_mac_d    = arp_response_mac;
                        state_d       = StSend;
                        hdr_ready_d   = 1'b1;
                        m_hdr_valid_d = 1'b1;
                    end
                end else if (timer_q <= TMR_W'(1)) begin
                    // Counter reaches zero this cycle: the attempt has expired.
                    timer_d = '0;
                    if (attempt_q < ATT_W'(ARP_RETRIES)) begin
                        attempt_d = attempt_q + 1'b1;
                        state_d   = StArpReq;
                    end else begin
                        state_d     = StDrop;
                        hdr_ready_d = 1'b1;
                        tx_err_d    = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StSend: begin
                if (m_ip_hdr_ready) begin
                    m_hdr_valid_d = 1'b0;
                end
                if (s_ip_payload_axis_tvalid && m_ip_payload_axis_tready &&
                    s_ip_payload_axis_tlast) begin
                    state_d = StIdle;
                end
            end
            StDrop: begin
                if (s_ip_payload_axis_tvalid && s_ip_payload_axis_tlast) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Flush overrides a same-cycle fill; the pointer is left alone.
        if (cache_flush) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            hdr_ready_q   <= 1'b0;
            m_hdr_valid_q <= 1'b0;
            dest_mac_q    <= 48'h0;
            arp_ip_q      <= 32'h0;
            tx_err_q      <= 1'b0;
            hit_q         <= 1'b0;
            timer_q       <= '0;
            attempt_q     <= '0;
            ptr_q         <= '0;
            valid_q       <= '0;
            for (int i = 0; i < CACHE_ENTRIES; i++) begin
                cache_ip_q[i]  <= 32'h0;
                cache_mac_q[i] <= 48'h0;
            end
        end else begin
            state_q       <= state_d;
            hdr_ready_q   <= hdr_ready_d;
            m_hdr_valid_q <= m_hdr_valid_d;
            dest_mac_q    <= dest_mac_d;
            arp_ip_q      <= arp_ip_d;
            tx_err_q      <= tx_err_d;
            hit_q         <= hit_d;
            timer_q       <= timer_d;
            attempt_q     <= attempt_d;
            ptr_q         <= ptr_d;
            valid_q       <= valid_d;
            cache_ip_q    <= cache_ip_d;
            cache_mac_q   <= cache_mac_d;
        end
    end

    assign s_ip_hdr_ready      = hdr_ready_q;
    assign m_ip_hdr_valid      = m_hdr_valid_q;
    assign m_eth_dest_mac      = dest_mac_q;
    assign arp_request_ip      = arp_ip_q;
    assign tx_error_arp_failed = tx_err_q;
    assign cache_hit           = hit_q;
    assign arp_request_valid   = (state_q == StArpReq);
    assign arp_response_ready  = (state_q == StArpWait);

    always_comb begin
        s_ip_payload_axis_tready = 1'b0;
        m_ip_payload_axis_tvalid = 1'b0;
        if (state_q == StSend) begin
            s_ip_payload_axis_tready = m_ip_payload_axis_tready;
            m_ip_payload_axis_tvalid = s_ip_payload_axis_tvalid;
        end else if (state_q == StDrop) begin
            s_ip_payload_axis_tready = 1'b1;
        end
    end

endmodule

// File: tb/tb_ip_tx_resolver.sv
// Directed bench for ip_tx_resolver (2-entry cache, 8-cycle timeout, 2 retries).
module tb_ip_tx_resolver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_ip_hdr_valid;
    logic        s_ip_hdr_ready;
    logic [31:0] s_ip_dest_ip;
    logic        s_ip_payload_axis_tvalid;
    logic        s_ip_payload_axis_tready;
    logic        s_ip_payload_axis_tlast;
    logic        m_ip_hdr_valid;
    logic        m_ip_hdr_ready;
    logic [47:0] m_eth_dest_mac;
    logic        m_ip_payload_axis_tvalid;
    logic        m_ip_payload_axis_tready;
    logic        arp_request_valid;
    logic        arp_request_ready;
    logic [31:0] arp_request_ip;
    logic        arp_response_valid;
    logic        arp_response_ready;
    logic        arp_response_error;
    logic [47:0] arp_response_mac;
    logic [31:0] local_ip;
    logic [31:0] subnet_mask;
    logic        cache_flush;
    logic        tx_error_arp_failed;
    logic        cache_hit;

    int n_cmp = 0;
    int n_bad = 0;

    // Monitor/responder state, written only by the monitor process.
    int cycle = 0;
    int arp_hs = 0;
    int hs_cyc [8];
    int err_cnt = 0;
    int hit_cnt = 0;
    int mtv_cnt = 0;

    // Responder controls, written only by the main process.
    logic        resp_en = 1'b1;
    logic        resp_err = 1'b0;
    logic [47:0] resp_mac = 48'h0;

    ip_tx_resolver #(
        .CACHE_ENTRIES(2),
        .ARP_TIMEOUT  (8),
        .ARP_RETRIES  (2)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .s_ip_hdr_valid          (s_ip_hdr_valid),
        .s_ip_hdr_ready          (s_ip_hdr_ready),
        .s_ip_dest_ip            (s_ip_dest_ip),
        .s_ip_payload_axis_tvalid(s_ip_payload_axis_tvalid),
        .s_ip_payload_axis_tready(s_ip_payload_axis_tready),
        .s_ip_payload_axis_tlast (s_ip_payload_axis_tlast),
        .m_ip_hdr_valid          (m_ip_hdr_valid),
        .m_ip_hdr_ready          (m_ip_hdr_ready),
        .m_eth_dest_mac          (m_eth_dest_mac),
        .m_ip_payload_axis_tvalid(m_ip_payload_axis_tvalid),
        .m_ip_payload_axis_tready(m_ip_payload_axis_tready),
        .arp_request_valid       (arp_request_valid),
        .arp_request_ready       (arp_request_ready),
        .arp_request_ip          (arp_request_ip),
        .arp_response_valid      (arp_response_valid),
        .arp_response_ready      (arp_response_ready),
        .arp_response_error      (arp_response_error),
        .arp_response_mac        (arp_response_mac),
        .local_ip                (local_ip),
        .subnet_mask             (subnet_mask),
        .cache_flush             (cache_flush),
        .tx_error_arp_failed     (tx_error_arp_failed),
        .cache_hit               (cache_hit)
    );

    always #5 clk = ~clk;

    // Samples on the falling edge; answers ARP immediately when enabled.
    initial begin
        arp_response_valid = 1'b0;
        arp_response_error = 1'b0;
        arp_response_mac   = 48'h0;
        forever begin
            @(negedge clk);
            cycle++;
            if (arp_request_valid && arp_request_ready) begin
                if (arp_hs < 8) hs_cyc[arp_hs] = cycle;
                arp_hs++;
            end
            if (tx_error_arp_failed) err_cnt++;
            if (cache_hit) hit_cnt++;
            if (m_ip_payload_axis_tvalid) mtv_cnt++;
            arp_response_valid = resp_en && arp_response_ready;
            arp_response_error = resp_err;
            arp_response_mac   = resp_mac;
        end
    end

    // Offers a header and waits (bounded) for s_ip_hdr_ready.
    task automatic send_hdr(input logic [31:0] ip, output int lat, output logic [47:0] mac,
                            output logic mval, output logic [31:0] aip);
        s_ip_hdr_valid = 1'b1;
        s_ip_dest_ip   = ip;
        lat = 0;
        mac = 48'h0;
        mval = 1'b0;
        aip = 32'h0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (s_ip_hdr_ready) begin
                mac  = m_eth_dest_mac;
                mval = m_ip_hdr_valid;
                aip  = arp_request_ip;
                break;
            end
        end
        s_ip_hdr_valid = 1'b0;
    endtask

    // Drives a payload of the given length, one beat per cycle.
    task automatic send_payload(input int beats);
        for (int b = 0; b < beats; b++) begin
            s_ip_payload_axis_tvalid = 1'b1;
            s_ip_payload_axis_tlast  = (b == beats - 1);
            @(posedge clk);
            #1;
        end
        s_ip_payload_axis_tvalid = 1'b0;
        s_ip_payload_axis_tlast  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (s_ip_hdr_ready !== 1'b0 || m_ip_hdr_valid !== 1'b0 || arp_request_valid !== 1'b0 ||
            arp_response_ready !== 1'b0 || s_ip_payload_axis_tready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got hr=%b mv=%b rq=%b rr=%b tr=%b, need all 0",
                     s_ip_hdr_ready, m_ip_hdr_valid, arp_request_valid, arp_response_ready,
                     s_ip_payload_axis_tready);
        end
        n_cmp++;
        if (m_eth_dest_mac !== 48'h0 || arp_request_ip !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_regs: got mac=%h ip=%h, need 0", m_eth_dest_mac, arp_request_ip);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_multicast();
        int lat; logic [47:0] mac; logic mv; logic [31:0] aip; int hs0;
        hs0 = arp_hs;
        send_hdr(32'hEF01_0203, lat, mac, mv, aip);
        n_cmp++;
        if (mac !== 48'h0100_5E01_0203) begin
            n_bad++; $display("FAIL mcast_mac: got %h need 01005e010203", mac);
        end
        n_cmp++;
        if (lat !== 1 || mv !== 1'b1) begin
            n_bad++; $display("FAIL mcast_lat: got lat=%0d mv=%b need 1/1", lat, mv);
        end
        send_payload(2);
        n_cmp++;
        if (arp_hs - hs0 !== 0) begin
            n_bad++; $display("FAIL mcast_noarp: got %0d requests need 0", arp_hs - hs0);
        end
        n_cmp++;
        if (m_ip_hdr_valid !== 1'b0 || s_ip_payload_axis_tready !== 1'b0) begin
            n_bad++;
            $display("FAIL mcast_done: got mv=%b tr=%b need 0/0", m_ip_hdr_valid,
                     s_ip_payload_axis_tready);
        end
    endtask

    task automatic test_broadcast();
        int lat; logic [47:0] mac; logic mv; logic [31:0] aip; int hs0; int mt0;
        hs0 = arp_hs;
        mt0 = mtv_cnt;
        send_hdr(32'hC0A8_01FF, lat, mac, mv, aip);
        n_cmp++;
        if (mac !== 48'hFFFF_FFFF_FFFF || lat !== 1) begin
            n_bad++; $display("FAIL bcast_subnet: got mac=%h lat=%0d need ffffffffffff/1", mac, lat);
        end
        send_payload(3);
        n_cmp++;
        if (mtv_cnt - mt0 !== 3) begin
            n_bad++; $display("FAIL bcast_fwd: got %0d valid beats need 3", mtv_cnt - mt0);
        end
        send_hdr(32'hFFFF_FFFF, lat, mac, mv, aip);
        n_cmp++;
        if (mac !== 48'hFFFF_FFFF_FFFF || lat !== 1 || arp_hs - hs0 !== 0) begin
            n_bad++;
            $display("FAIL bcast_limited: got mac=%h lat=%0d arp=%0d need ffffffffffff/1/0",
                     mac, lat, arp_hs - hs0);
        end
        send_payload(1);
        // Off-subnet all-ones host part is not a broadcast.
        resp_mac = 48'h02AA_BBCC_0001;
        send_hdr(32'h0A00_00FF, lat, mac, mv, aip);
        n_cmp++;
        if (arp_hs - hs0 !== 1 || mac !== 48'h02AA_BBCC_0001 || aip !== 32'h0A00_00FF) begin
            n_bad++;
            $display("FAIL bcast_offnet: got arp=%0d mac=%h ip=%h need 1/02aabbcc0001/0a0000ff",
                     arp_hs - hs0, mac, aip);
        end
        n_cmp++;
        if (lat !== 3) begin
            n_bad++; $display("FAIL miss_latency: got %0d need 3", lat);
        end
        send_payload(1);
    endtask

    task automatic test_miss_hit();
        int lat; logic [47:0] mac; logic mv; logic [31:0] aip; int hs0; int h0;
        hs0 = arp_hs;
        h0 = hit_cnt;
        resp_mac = 48'h0200_0000_0014;
        send_hdr(32'hC0A8_0114, lat, mac, mv, aip);
        n_cmp++;
        if (arp_hs - hs0 !== 1 || mac !== 48'h0200_0000_0014 || hit_cnt - h0 !== 0) begin
            n_bad++;
            $display("FAIL miss_fill: got arp=%0d mac=%h hit=%0d need 1/020000000014/0",
                     arp_hs - hs0, mac, hit_cnt - h0);
        end
        send_payload(2);
        resp_mac = 48'hDEAD_DEAD_DEAD;
        send_hdr(32'hC0A8_0114, lat, mac, mv, aip);
        n_cmp++;
        if (arp_hs - hs0 !== 1 || mac !== 48'h0200_0000_0014 || lat !== 1) begin
            n_bad++;
            $display("FAIL hit_mac: got arp=%0d mac=%h lat=%0d need 1/020000000014/1",
                     arp_hs - hs0, mac, lat);
        end
        send_payload(1);
        n_cmp++;
        if (hit_cnt - h0 !== 1) begin
            n_bad++; $display("FAIL hit_pulse: got %0d pulses need 1", hit_cnt - h0);
        end
    endtask

    task automatic test_timeout_retry();
        int lat; logic [47:0] mac; logic mv; logic [31:0] aip; int hs0; int e0; int mt0;
        hs0 = arp_hs;
        e0 = err_cnt;
        resp_en = 1'b0;
        send_hdr(32'h0A00_0063, lat, mac, mv, aip);
        n_cmp++;
        if (arp_hs - hs0 !== 3) begin
            n_bad++; $display("FAIL retry_count: got %0d requests need 3", arp_hs - hs0);
        end
        n_cmp++;
        if (hs0 + 2 < 8 && (hs_cyc[hs0 + 1] - hs_cyc[hs0] !== 8 ||
                            hs_cyc[hs0 + 2] - hs_cyc[hs0 + 1] !== 8)) begin
            n_bad++;
            $display("FAIL retry_spacing: got %0d,%0d cycles need 8,8",
                     hs_cyc[hs0 + 1] - hs_cyc[hs0], hs_cyc[hs0 + 2] - hs_cyc[hs0 + 1]);
        end
        n_cmp++;
        if (lat !== 25 || mv !== 1'b0) begin
            n_bad++; $display("FAIL drop_latency: got lat=%0d mv=%b need 25/0", lat, mv);
        end
        mt0 = mtv_cnt;
        send_payload(5);
        n_cmp++;
        if (err_cnt - e0 !== 1) begin
            n_bad++; $display("FAIL drop_err_pulse: got %0d pulses need 1", err_cnt - e0);
        end
        n_cmp++;
        if (mtv_cnt - mt0 !== 0 || s_ip_payload_axis_tready !== 1'b0) begin
            n_bad++;
            $display("FAIL drop_gate: got mtvalid=%0d tr=%b need 0/0", mtv_cnt - mt0,
                     s_ip_payload_axis_tready);
        end
        resp_en = 1'b1;
    endtask

    task automatic test_replace_flush();
        int lat; logic [47:0] mac; logic mv; logic [31:0] aip; int hs0;
        logic [31:0] ips [3];
        ips[0] = 32'h0A00_0001;
        ips[1] = 32'h0A00_0002;
        ips[2] = 32'h0A00_0003;
        cache_flush = 1'b1;
        @(posedge clk);
        #1;
        cache_flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            resp_mac = 48'h0200_0000_00A0 + 48'(k);
            send_hdr(ips[k], lat, mac, mv, aip);
            send_payload(1);
        end
        resp_mac = 48'h0200_0000_00FF;
        hs0 = arp_hs;
        send_hdr(ips[1], lat, mac, mv, aip);
        send_payload(1);
        n_cmp++;
        if (arp_hs - hs0 !== 0 || mac !== 48'h0200_0000_00A1) begin
            n_bad++;
            $display("FAIL repl_b_hit: got arp=%0d mac=%h need 0/0200000000a1", arp_hs - hs0, mac);
        end
        send_hdr(ips[0], lat, mac, mv, aip);
        send_payload(1);
        n_cmp++;
        if (arp_hs - hs0 !== 1 || mac !== 48'h0200_0000_00FF) begin
            n_bad++;
            $display("FAIL repl_a_miss: got arp=%0d mac=%h need 1/0200000000ff", arp_hs - hs0, mac);
        end
        send_hdr(ips[2], lat, mac, mv, aip);
        send_payload(1);
        n_cmp++;
        if (arp_hs - hs0 !== 1 || mac !== 48'h0200_0000_00A2) begin
            n_bad++;
            $display("FAIL repl_c_hit: got arp=%0d mac=%h need 1/0200000000a2", arp_hs - hs0, mac);
        end
        cache_flush = 1'b1;
        @(posedge clk);
        #1;
        cache_flush = 1'b0;
        send_hdr(ips[2], lat, mac, mv, aip);
        send_payload(1);
        n_cmp++;
        if (arp_hs - hs0 !== 2 || mac !== 48'h0200_0000_00FF) begin
            n_bad++;
            $display("FAIL flush_rearp: got arp=%0d mac=%h need 2/0200000000ff", arp_hs - hs0, mac);
        end
    endtask

    task automatic test_reset_mid_send();
        int lat; logic [47:0] mac; logic mv; logic [31:0] aip;
        send_hdr(32'hC0A8_01FF, lat, mac, mv, aip);
        for (int b = 0; b < 3; b++) begin
            s_ip_payload_axis_tvalid = 1'b1;
            s_ip_payload_axis_tlast  = 1'b0;
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (m_ip_payload_axis_tvalid !== 1'b0 || s_ip_payload_axis_tready !== 1'b0 ||
            m_ip_hdr_valid !== 1'b0 || m_eth_dest_mac !== 48'h0 || s_ip_hdr_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_send: got mtv=%b tr=%b mv=%b mac=%h hr=%b need all 0",
                     m_ip_payload_axis_tvalid, s_ip_payload_axis_tready, m_ip_hdr_valid,
                     m_eth_dest_mac, s_ip_hdr_ready);
        end
        s_ip_payload_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_hdr(32'hE07F_0001, lat, mac, mv, aip);
        n_cmp++;
        if (mac !== 48'h0100_5E7F_0001 || lat !== 1 || mv !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_recover: got mac=%h lat=%0d mv=%b need 01005e7f0001/1/1",
                     mac, lat, mv);
        end
        send_payload(2);
    endtask

    initial begin
        rst_n = 1'b0;
        s_ip_hdr_valid = 1'b0;
        s_ip_dest_ip = 32'h0;
        s_ip_payload_axis_tvalid = 1'b0;
        s_ip_payload_axis_tlast = 1'b0;
        m_ip_hdr_ready = 1'b1;
        m_ip_payload_axis_tready = 1'b1;
        arp_request_ready = 1'b1;
        local_ip = 32'hC0A8_010A;
        subnet_mask = 32'hFFFF_FF00;
        cache_flush = 1'b0;

        test_reset();
        test_multicast();
        test_broadcast();
        test_miss_hit();
        test_timeout_retry();
        test_replace_flush();
        test_reset_mid_send();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
